// File: rtl/sound_sequencer_pkg.sv
// Shared types, note tables and arbitration helpers for the sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    SND_NONE   = 2'd0,
    SND_BUTTON = 2'd1,
    SND_GOOD   = 2'd2,
    SND_BAD    = 2'd3
  } sound_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } seq_state_t;

  localparam int PERIOD_W = 8;

  // Entry [0] is the first note played.
  localparam logic [PERIOD_W-1:0]      BUTTON_TBL = 8'd20;
  localparam logic [2:0][PERIOD_W-1:0] GOOD_TBL   = {8'd24, 8'd32, 8'd40};
  localparam logic [1:0][PERIOD_W-1:0] BAD_TBL    = {8'd90, 8'd60};

  localparam logic [1:0] BUTTON_CNT = 2'd1;
  localparam logic [1:0] GOOD_CNT   = 2'd3;
  localparam logic [1:0] BAD_CNT    = 2'd2;

  function automatic logic [1:0] note_count(input sound_t s);
    case (s)
      SND_BUTTON: return BUTTON_CNT;
      SND_GOOD:   return GOOD_CNT;
      SND_BAD:    return BAD_CNT;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic logic [PERIOD_W-1:0] get_period(input sound_t s, input logic [1:0] idx);
    logic [PERIOD_W-1:0] p;
    p = '0;
    case (s)
      SND_BUTTON: if (idx == 2'd0) p = BUTTON_TBL;
      SND_GOOD:   if (idx != 2'd3) p = GOOD_TBL[idx];
      SND_BAD:    if (!idx[1]) p = BAD_TBL[idx[0]];
      default:    p = '0;
    endcase
    return p;
  endfunction

  // Event vectors are {bad, good, button}.
  function automatic sound_t highest(input logic [2:0] v);
    if (v[2]) return SND_BAD;
    if (v[1]) return SND_GOOD;
    if (v[0]) return SND_BUTTON;
    return SND_NONE;
  endfunction

  function automatic logic [2:0] sound_bit(input sound_t s);
    case (s)
      SND_BUTTON: return 3'b001;
      SND_GOOD:   return 3'b010;
      SND_BAD:    return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// Event/tone bundle between game logic, sequencer and sound generator.
// Optional mute input is present when SOUND_SEQ_MUTE_EN is defined.
interface sound_sequencer_if;
  logic       button_i;
  logic       goodColl_i;
  logic       badColl_i;
`ifdef SOUND_SEQ_MUTE_EN
  logic       mute_i;
`endif
  logic       tone_en_o;
  logic [7:0] tone_period_o;
  logic [1:0] active_sound_o;
  logic       busy_o;
  logic       done_o;

`ifdef SOUND_SEQ_MUTE_EN
  modport master (output button_i, goodColl_i, badColl_i, mute_i,
                  input  tone_en_o, tone_period_o, active_sound_o, busy_o, done_o);
  modport slave  (input  button_i, goodColl_i, badColl_i, mute_i,
                  output tone_en_o, tone_period_o, active_sound_o, busy_o, done_o);
`else
  modport master (output button_i, goodColl_i, badColl_i,
                  input  tone_en_o, tone_period_o, active_sound_o, busy_o, done_o);
  modport slave  (input  button_i, goodColl_i, badColl_i,
                  output tone_en_o, tone_period_o, active_sound_o, busy_o, done_o);
`endif
endinterface

// File: rtl/sound_sequencer_note_timer.sv
// Loadable down-counter timing notes and gaps; expire is high while the count is zero.
module sound_note_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/sound_sequencer.sv
// Priority arbiter and note sequencer feeding the DAC sound generator.
// SOUND_SEQ_MUTE_EN adds a mute input that silences the tone outputs only.
module sound_sequencer #(
  parameter int NOTE_TICKS = 25,
  parameter int GAP_TICKS  = 2,
  parameter int TIMER_W    = 8
) (
  input logic               clk,
  input logic               rst_i,
  sound_sequencer_if.slave  bus
);
  import sound_pkg::*;

  localparam logic [TIMER_W-1:0] NOTE_LOAD = TIMER_W'(NOTE_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam bit                 HAS_GAP   = (GAP_TICKS > 0);

  seq_state_t          state;
  sound_t              active;
  sound_t              new_top;
  sound_t              idle_pick;
  sound_t              start_snd;
  logic [1:0]          note_idx;
  logic [2:0]          events;
  logic [2:0]          pending;
  logic [2:0]          pending_nxt;
  logic                tone_en;
  logic [PERIOD_W-1:0] tone_period;
  logic                busy;
  logic                done;
  logic                expire;
  logic                start;
  logic                preempt;
  logic                advance;
  logic                last_note;
  logic                finish;
  logic                busy_nxt;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;

  assign events = {bus.badColl_i, bus.goodColl_i, bus.button_i};

  // Arbitration: new events beat the active sound only when strictly higher;
  // everything else that was not started lands in (or merges into) pending.
  always_comb begin
    new_top     = highest(events);
    idle_pick   = highest(events | pending);
    preempt     = (state != IDLE) && (new_top > active);
    start       = preempt || ((state == IDLE) && (idle_pick != SND_NONE));
    start_snd   = (state == IDLE) ? idle_pick : new_top;
    last_note   = (note_idx == note_count(active) - 2'd1);
    advance     = (state != IDLE) && expire && !preempt;
    finish      = advance && (state == PLAY) && last_note;
    pending_nxt = (pending | events) & ~(start ? sound_bit(start_snd) : 3'b000);
    busy_nxt    = start || ((state != IDLE) && !finish) || (pending_nxt != 3'b000);
    tmr_load    = start || (advance && !finish);
    tmr_val     = (!start && (state == PLAY) && HAS_GAP) ? GAP_LOAD : NOTE_LOAD;
  end

  sound_note_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= IDLE;
      active      <= SND_NONE;
      note_idx    <= 2'd0;
      pending     <= 3'b000;
      tone_en     <= 1'b0;
      tone_period <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pending <= pending_nxt;
      busy    <= busy_nxt;
      done    <= 1'b0;
      if (start) begin
        state       <= PLAY;
        active      <= start_snd;
        note_idx    <= 2'd0;
        tone_en     <= 1'b1;
        tone_period <= get_period(start_snd, 2'd0);
      end else if (advance) begin
        if (finish) begin
          state       <= IDLE;
          active      <= SND_NONE;
          note_idx    <= 2'd0;
          tone_en     <= 1'b0;
          tone_period <= '0;
          done        <= 1'b1;
        end else if ((state == GAP) || !HAS_GAP) begin
          state       <= PLAY;
          note_idx    <= note_idx + 2'd1;
          tone_en     <= 1'b1;
          tone_period <= get_period(active, note_idx + 2'd1);
        end else begin
          state       <= GAP;
          tone_en     <= 1'b0;
          tone_period <= '0;
        end
      end
    end
  end

`ifdef SOUND_SEQ_MUTE_EN
  assign bus.tone_en_o     = tone_en & ~bus.mute_i;
  assign bus.tone_period_o = bus.mute_i ? '0 : tone_period;
`else
  assign bus.tone_en_o     = tone_en;
  assign bus.tone_period_o = tone_period;
`endif
  assign bus.active_sound_o = active;
  assign bus.busy_o         = busy;
  assign bus.done_o         = done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed and randomized bench for sound_sequencer against a timeline model.
// Exercises the mute input as well when SOUND_SEQ_MUTE_EN is defined.
module tb_sound_sequencer;

  localparam int N = 4;
  localparam int G = 1;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  sound_sequencer_if bus();

  sound_sequencer #(
    .NOTE_TICKS (N),
    .GAP_TICKS  (G),
    .TIMER_W    (W)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: the sound in progress is described by its id and the cycle its
  // first note sounded; everything else follows from the elapsed offset.
  int       cur    = 0;
  int       start  = 0;
  int       now    = 0;
  bit [3:1] pend   = '0;
  bit       done_m = 1'b0;
  bit       mute_m = 1'b0;

  function automatic int cnt(input int s);
    case (s)
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int per(input int s, input int n);
    int good_tbl[3] = '{40, 32, 24};
    int bad_tbl[2]  = '{60, 90};
    case (s)
      1: return 20;
      2: return good_tbl[n];
      3: return bad_tbl[n];
      default: return 0;
    endcase
  endfunction

  function automatic int top(input bit [3:1] v);
    if (v[3]) return 3;
    if (v[2]) return 2;
    if (v[1]) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare();
    int off;
    int e_en, e_per, e_act, e_busy;
    if (cur != 0) begin
      off    = now - start;
      e_en   = ((off % (N + G)) < N) ? 1 : 0;
      e_per  = (e_en != 0) ? per(cur, off / (N + G)) : 0;
      e_act  = cur;
      e_busy = 1;
    end else begin
      e_en   = 0;
      e_per  = 0;
      e_act  = 0;
      e_busy = (pend != 0) ? 1 : 0;
    end
    if (mute_m) begin
      e_en  = 0;
      e_per = 0;
    end
    chk("tone_en",     32'(bus.tone_en_o),      e_en);
    chk("tone_period", 32'(bus.tone_period_o),  e_per);
    chk("active",      32'(bus.active_sound_o), e_act);
    chk("busy",        32'(bus.busy_o),         e_busy);
    chk("done",        32'(bus.done_o),         32'(done_m));
  endtask

  task automatic step(input bit r, input bit b, input bit g, input bit bd);
    bit [3:1] ev;
    int       t, p;
    bit       fin;
    rst_i          = r;
    bus.button_i   = b;
    bus.goodColl_i = g;
    bus.badColl_i  = bd;
`ifdef SOUND_SEQ_MUTE_EN
    bus.mute_i     = mute_m;
`endif
    ev     = {bd, g, b};
    done_m = 1'b0;
    if (r) begin
      cur  = 0;
      pend = '0;
    end else begin
      fin = (cur != 0) && (now - start == cnt(cur) * (N + G) - G - 1);
      t   = top(ev);
      if (cur == 0) begin
        p    = top(ev | pend);
        pend = ev | pend;
        if (p != 0) begin
          pend[p] = 1'b0;
          cur     = p;
          start   = now + 1;
        end
      end else if (t > cur) begin
        pend    = pend | ev;
        pend[t] = 1'b0;
        cur     = t;
        start   = now + 1;
      end else begin
        pend = pend | ev;
        if (fin) begin
          cur    = 0;
          done_m = 1'b1;
        end
      end
    end
    now++;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic settle();
    for (int i = 0; i < 60 && (cur != 0 || pend != 0 || done_m); i++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    int done_at, p6, btn_at, busy_low, dones, good_seen, starts;
    logic [1:0] prev;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_active", 32'(bus.active_sound_o), 0);

    // Single good collision: observations are indexed by cycle after the pulse
    step(0, 0, 1, 0);
    chk("good_first_period", 32'(bus.tone_period_o), 40);
    done_at = -1;
    p6      = -1;
    for (int c = 2; c <= 17; c++) begin
      step(0, 0, 0, 0);
      if (c == 6) p6 = int'(bus.tone_period_o);
      if (bus.done_o === 1'b1 && done_at < 0) done_at = c;
    end
    chk("good_note1_period", p6, 32);
    chk("good_done_cycle", done_at, 15);
    settle();

    // Reset mid-sound aborts without done
    step(0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midrst_tone", 32'(bus.tone_en_o), 0);
    dones = 0;
    repeat (20) begin
      step(0, 0, 0, 0);
      if (bus.done_o === 1'b1) dones++;
    end
    chk("midrst_no_done", dones, 0);

    // Simultaneous button + good
    step(0, 1, 1, 0);
    chk("simul_first", 32'(bus.active_sound_o), 2);
    btn_at   = -1;
    busy_low = 0;
    for (int c = 2; c <= 25; c++) begin
      step(0, 0, 0, 0);
      if (bus.active_sound_o === 2'd1 && btn_at < 0) btn_at = c;
      if (c <= 19 && bus.busy_o !== 1'b1) busy_low++;
    end
    chk("simul_button_start", btn_at, 16);
    chk("simul_busy_held", busy_low, 0);
    settle();

    // Preemption of good by bad
    step(0, 0, 1, 0);
    for (int c = 2; c <= 7; c++) step(0, 0, 0, (c == 7));
    chk("preempt_period", 32'(bus.tone_period_o), 60);
    chk("preempt_active", 32'(bus.active_sound_o), 3);
    dones     = 0;
    good_seen = 0;
    for (int c = 8; c <= 30; c++) begin
      step(0, 0, 0, 0);
      if (bus.active_sound_o === 2'd2) good_seen++;
      if (bus.done_o === 1'b1) dones++;
    end
    chk("preempt_done_count", dones, 1);
    chk("preempt_no_resume", good_seen, 0);
    settle();

    // Repeated buttons during bad merge into one
    step(0, 0, 0, 1);
    prev   = bus.active_sound_o;
    starts = 0;
    for (int c = 2; c <= 30; c++) begin
      step(0, (c == 3 || c == 5 || c == 8), 0, 0);
      if (bus.active_sound_o === 2'd1 && prev !== 2'd1) starts++;
      prev = bus.active_sound_o;
    end
    chk("merge_button_plays", starts, 1);
    settle();

`ifdef SOUND_SEQ_MUTE_EN
    // Muted good collision still completes on time
    mute_m = 1'b1;
    step(0, 0, 1, 0);
    done_at = -1;
    for (int c = 2; c <= 17; c++) begin
      step(0, 0, 0, 0);
      if (bus.done_o === 1'b1 && done_at < 0) done_at = c;
    end
    chk("mute_done_cycle", done_at, 15);
    mute_m = 1'b0;
    settle();
`endif

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
`ifdef SOUND_SEQ_MUTE_EN
      mute_m = ($urandom_range(0, 9) == 0);
`endif
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 15) == 0));
    end
    mute_m = 1'b0;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Front-end controller for the 8-bit DAC sound generator. Accepts one-cycle event pulses (button click, good collision, bad collision) and arbitrates between them by fixed priority. For the winning sound it plays a short note sequence by driving a tone half-period and enable to the generator, timing each note and the gap after it. Sits between the game/event logic and the sound generator datapath.

Parameters:
NOTE_TICKS, 25, clock cycles each note is held (≥1)
GAP_TICKS, 2, silent cycles between consecutive notes of one sound (0 = no gap)
TIMER_W, 8, width of the note/gap down-counter (must hold max(NOTE_TICKS, GAP_TICKS)-1)

Ports:
clk  in  1  system clock
rst_i  in  1  synchronous, active-high reset
button_i  in  1  button click event pulse (lowest priority)
goodColl_i  in  1  good collision event pulse (middle priority)
badColl_i  in  1  bad collision event pulse (highest priority)
tone_en_o  out  1  generator enable; high only while a note is sounding
tone_period_o  out  8  half-period handed to generator; 0 when tone_en_o low
active_sound_o  out  2  sound_t code of sound in progress; SND_NONE when idle
busy_o  out  1  high when state != IDLE or any pending bit set
done_o  out  1  one-cycle pulse when a sound completes naturally

Behaviour:
- Reset: on a clk edge with rst_i high, go to IDLE. Outputs go to tone_en_o=0, tone_period_o=0, active_sound_o=SND_NONE, busy_o=0, done_o=0. Pending flags and timer are cleared. Reset mid-sound aborts it with no done_o.
- Note tables (period per note): SND_BUTTON {20}; SND_GOOD {40,32,24}; SND_BAD {60,90}.
- All outputs are registered. An event sampled at edge k in IDLE gives tone_en_o=1 and note 0 period from cycle k+1.
- States:
  - IDLE: select the highest priority among new events and pending flags. Load note 0 and set the timer to NOTE_TICKS-1, then go to PLAY.
  - PLAY: decrement the timer. At 0 with notes remaining, go to GAP with timer GAP_TICKS-1, or straight to PLAY with the next note if GAP_TICKS=0. At 0 on the last note, go to IDLE, pulse done_o in the IDLE cycle, and return active_sound_o to SND_NONE.
  - GAP: tone_en_o=0 and tone_period_o=0. At timer 0, go to PLAY with the next note.
- At least one IDLE cycle always separates two sounds. A pending sound starts the cycle after that IDLE cycle.
- Priority: badColl > goodColl > button.
- Simultaneous events: the highest one is served; the others set their pending flags.
- Event during PLAY/GAP with strictly higher priority than the active sound: preempt. Next cycle plays the new sound's note 0. The aborted sound is discarded (not re-queued) and gives no done_o.
- Event of equal or lower priority during PLAY/GAP: set its pending flag. Repeats while the flag is set merge into one.
- A pending flag clears when its sound starts. Pending flags are served highest-first.
- An event arriving on the same edge as the final note expiry is handled as pending/preempt first. If it preempts, no done_o is issued.
- Event held high for several cycles counts as one event per cycle. Any resulting duplicates are absorbed by pending merge.

Optional Feature:
Macro SOUND_SEQ_MUTE_EN.
- Defined: adds input port mute_i (1 bit). While mute_i=1, tone_en_o and tone_period_o are forced to 0. Sequencing, timing, busy_o and done_o continue unchanged.
- Undefined: no mute_i port; outputs behave exactly as above.

Decomposition:
- Package sound_pkg holds:
  - enum sound_t (2 bits): SND_NONE=0, SND_BUTTON=1, SND_GOOD=2, SND_BAD=3
  - enum seq_state_t: IDLE, PLAY, GAP
  - localparam note tables and per-sound note counts
  - function get_period(sound_t, note_idx)
- One sub-module: sound_note_timer, a loadable TIMER_W down-counter with load, load_val and expire (count==0) outputs.
- The FSM, arbiter and pending register stay in sound_sequencer.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles mid-sound (NOTE_TICKS=4, GAP_TICKS=1) -> next edge all outputs 0, active_sound_o=SND_NONE, busy_o=0; no done_o.
- Single good: goodColl_i pulse at cycle 0 -> tone_en_o=1 with period 40 on cycles 1-4, 0 on 5, 32 on 6-9, 0 on 10, 24 on 11-14; IDLE at 15 with done_o=1 for one cycle.
- Simultaneous: button_i and goodColl_i same cycle -> GOOD plays first; button (period 20, 4 cycles) starts one cycle after GOOD's IDLE cycle; busy_o high throughout.
- Preemption: badColl_i at cycle 6 during GOOD -> cycle 7 period 60, active_sound_o=3; GOOD never resumes; single done_o after BAD ends.
- Merge: button_i pulsed 3 times during BAD -> button plays exactly once afterwards.
- Mute (SOUND_SEQ_MUTE_EN defined): mute_i=1 during GOOD -> tone_en_o=0 and tone_period_o=0 for that span, yet done_o still at cycle 15.
